adder_arbiter: RTL and testbench
================================

# adder_arbiter

Round-robin arbiter and sequencer sharing one registered 4-bit adder among several requesters. Each requester presents an operand pair. The arbiter grants one requester and drives the adder's operand/enable inputs. It waits for the adder's registered sum, then returns Sum/Overflow tagged with the requester index over a valid/ready response port. It sits between client logic and the single adder instance, which it owns exclusively.

## Interface
- NUM_REQ, 4: number of requesters; legal range 2..8.
- WIDTH, 4: operand/sum width; must equal the adder width.
- ID_W, 2: width of Rsp_Id; must be at least ceil(log2(NUM_REQ)).
- Clk  in  1  single clock; all state changes on its rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- Req  in  NUM_REQ  per-requester request level; held until that requester's Gnt.
- Req_A  in  NUM_REQ*WIDTH  operand A; requester i occupies [i*WIDTH +: WIDTH].
- Req_B  in  NUM_REQ*WIDTH  operand B; same packing as Req_A.
- Gnt  out  NUM_REQ  one-hot grant; registered, one-cycle pulse.
- Add_A  out  WIDTH  to adder A.
- Add_B  out  WIDTH  to adder B.
- Add_En  out  1  to adder En.
- Add_Sum  in  WIDTH  from adder Sum.
- Add_Ovf  in  1  from adder Overflow (carry out).
- Rsp_Valid  out  1  response valid.
- Rsp_Ready  in  1  response accepted.
- Rsp_Id  out  ID_W  index of the granted requester.
- Rsp_Sum  out  WIDTH  captured sum.
- Rsp_Ovf  out  1  captured overflow.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- IDLE:
  - If any Req bit is set, select the winner.
  - Register Gnt = onehot(winner), Add_A/Add_B = the winner's operands, Add_En = 1, and latch the winner as the current id.
  - Go to ISSUE. With no request, stay in IDLE.
- ISSUE: the adder samples its operands at the closing edge. Clear Gnt and Add_En, then go to WAIT.
- WAIT: the adder output is now valid. Capture Rsp_Sum = Add_Sum, Rsp_Ovf = Add_Ovf and Rsp_Id = id, set Rsp_Valid = 1, then go to RESP.
- RESP: hold all Rsp_* outputs stable. When Rsp_Ready = 1 at an edge, clear Rsp_Valid, set ptr = (id+1) mod NUM_REQ, and go to IDLE.
- Round-robin winner: the first set Req bit at or after ptr, scanning upward with wrap-around. ptr resets to 0.
- Req is sampled only in IDLE. A Req asserted in any other state waits; it is never dropped or double-granted.
- Add_A/Add_B hold their last values outside IDLE→ISSUE. Add_En is high only during ISSUE.
- Arithmetic is performed entirely by the adder; the arbiter never modifies Sum/Ovf. Example: 9+8 gives Sum=1, Ovf=1.
- Reset mid-operation:
  - All state and outputs clear immediately; the in-flight op is discarded and no response is produced.
  - The adder has no reset and keeps its stale operands; this is harmless because Add_En=0.

## Timing
- Reset values: Gnt=0, Add_A=0, Add_B=0, Add_En=0, Rsp_Valid=0, Rsp_Id=0, Rsp_Sum=0, Rsp_Ovf=0.
- Req sampled at edge t:
  - Gnt and Add_En are high from t to t+1.
  - The adder registers its operands at t+1.
  - Rsp_Valid rises at t+2, for a latency of 2 cycles.
- The earliest Rsp_Ready acceptance is edge t+3, which returns the FSM to IDLE. The next grant is at t+4 at the earliest.
- Peak throughput is one operation per 4 cycles.
- A requester must drop Req, or update its operands for a new op, at the edge after it sees Gnt.
- Backpressure: Rsp_Ready low holds RESP indefinitely, with no new grant.

## Configuration
- ADDER_ARB_RR_EN defined: round-robin arbitration as described above.
- ADDER_ARB_RR_EN undefined:
  - Fixed priority; the lowest set Req index always wins.
  - ptr logic is removed.
  - All other behaviour and timing are identical.

## Test plan
- Reset: assert Rst_n=0 during WAIT of an op from client 1 → all outputs 0 immediately; after release, with no Req, Rsp_Valid stays 0 for 10 cycles.
- Single op: client 2 with A=9, B=8 → Gnt=4'b0100 for one cycle, Add_En high for one cycle, then Rsp_Valid with Rsp_Id=2, Rsp_Sum=1, Rsp_Ovf=1, two cycles after grant.
- No overflow: client 1 with A=7, B=8 → Rsp_Sum=15, Rsp_Ovf=0; Rsp_Ready held high → Rsp_Valid high for exactly one cycle.
- Contention: all four Req held continuously with Rsp_Ready=1 → grant order 0,1,2,3,0 with RR_EN; 0,0,0,0 without it. Grants are spaced 4 cycles apart.
- Backpressure: Rsp_Ready=0 for 5 cycles while Req=4'b1111 → Rsp_* stable, Gnt=0, Add_En=0 throughout; next Gnt 1 cycle after Ready is accepted.

Source files
------------

// File: rtl/adder_arbiter.sv
// Arbiter/sequencer sharing one registered adder among NUM_REQ requesters.
// ADDER_ARB_RR_EN selects round-robin arbitration; otherwise fixed lowest-index priority.
module adder_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                       Clk,
  input  logic                       Rst_n,
  input  logic [NUM_REQ-1:0]         Req,
  input  logic [NUM_REQ*WIDTH-1:0]   Req_A,
  input  logic [NUM_REQ*WIDTH-1:0]   Req_B,
  output logic [NUM_REQ-1:0]         Gnt,
  output logic [WIDTH-1:0]           Add_A,
  output logic [WIDTH-1:0]           Add_B,
  output logic                       Add_En,
  input  logic [WIDTH-1:0]           Add_Sum,
  input  logic                       Add_Ovf,
  output logic                       Rsp_Valid,
  input  logic                       Rsp_Ready,
  output logic [ID_W-1:0]            Rsp_Id,
  output logic [WIDTH-1:0]           Rsp_Sum,
  output logic                       Rsp_Ovf
);

  localparam int unsigned ST_W = 2;
  localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [ST_W-1:0] ST_ISSUE = 2'd1;
  localparam logic [ST_W-1:0] ST_WAIT  = 2'd2;
  localparam logic [ST_W-1:0] ST_RESP  = 2'd3;

  logic [ST_W-1:0]    state_q, state_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [NUM_REQ-1:0] gnt_d;
  logic [WIDTH-1:0]   add_a_d, add_b_d;
  logic               add_en_d;
  logic               rsp_valid_d;
  logic [ID_W-1:0]    rsp_id_d;
  logic [WIDTH-1:0]   rsp_sum_d;
  logic               rsp_ovf_d;

  logic [ID_W-1:0]    win;
  logic               any_req;
  int unsigned        base;
  int unsigned        idx;
  logic [NUM_REQ-1:0] req_sh;

`ifdef ADDER_ARB_RR_EN
  logic [ID_W-1:0]    ptr_q, ptr_d;
`endif

  // Winner: first set Req bit at or after base, wrapping around
  always_comb begin
    win     = '0;
    any_req = 1'b0;
    idx     = 0;
    req_sh  = '0;
`ifdef ADDER_ARB_RR_EN
    base = 32'(ptr_q);
`else
    base = 0;
`endif
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = base + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      req_sh = Req >> idx;
      if (!any_req && req_sh[0]) begin
        any_req = 1'b1;
        win     = ID_W'(idx);
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    gnt_d       = '0;
    add_a_d     = Add_A;
    add_b_d     = Add_B;
    add_en_d    = 1'b0;
    rsp_valid_d = Rsp_Valid;
    rsp_id_d    = Rsp_Id;
    rsp_sum_d   = Rsp_Sum;
    rsp_ovf_d   = Rsp_Ovf;
`ifdef ADDER_ARB_RR_EN
    ptr_d       = ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          gnt_d    = NUM_REQ'(1) << win;
          add_a_d  = WIDTH'(Req_A >> (32'(win) * WIDTH));
          add_b_d  = WIDTH'(Req_B >> (32'(win) * WIDTH));
          add_en_d = 1'b1;
          id_d     = win;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        rsp_sum_d   = Add_Sum;
        rsp_ovf_d   = Add_Ovf;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (Rsp_Ready) begin
          rsp_valid_d = 1'b0;
`ifdef ADDER_ARB_RR_EN
          ptr_d = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
`endif
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= ST_IDLE;
      id_q      <= '0;
      Gnt       <= '0;
      Add_A     <= '0;
      Add_B     <= '0;
      Add_En    <= 1'b0;
      Rsp_Valid <= 1'b0;
      Rsp_Id    <= '0;
      Rsp_Sum   <= '0;
      Rsp_Ovf   <= 1'b0;
`ifdef ADDER_ARB_RR_EN
      ptr_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      Gnt       <= gnt_d;
      Add_A     <= add_a_d;
      Add_B     <= add_b_d;
      Add_En    <= add_en_d;
      Rsp_Valid <= rsp_valid_d;
      Rsp_Id    <= rsp_id_d;
      Rsp_Sum   <= rsp_sum_d;
      Rsp_Ovf   <= rsp_ovf_d;
`ifdef ADDER_ARB_RR_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter with a behavioural registered adder and
// a transaction-level reference model of arbitration and arithmetic.
module tb_adder_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned W  = 4;
  localparam int unsigned IW = 2;

  logic              Clk = 1'b0;
  logic              Rst_n;
  logic [NR-1:0]     Req;
  logic [NR*W-1:0]   Req_A, Req_B;
  logic [NR-1:0]     Gnt;
  logic [W-1:0]      Add_A, Add_B;
  logic              Add_En;
  logic [W-1:0]      add_sum_q;
  logic              add_ovf_q;
  logic              Rsp_Valid;
  logic              Rsp_Ready;
  logic [IW-1:0]     Rsp_Id;
  logic [W-1:0]      Rsp_Sum;
  logic              Rsp_Ovf;

  always #5 Clk = ~Clk;

  // External adder: registers operands when enabled, no reset
  always @(posedge Clk) if (Add_En) {add_ovf_q, add_sum_q} <= {1'b0, Add_A} + {1'b0, Add_B};

  adder_arbiter #(.NUM_REQ(NR), .WIDTH(W), .ID_W(IW)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Req(Req), .Req_A(Req_A), .Req_B(Req_B),
    .Gnt(Gnt), .Add_A(Add_A), .Add_B(Add_B), .Add_En(Add_En),
    .Add_Sum(add_sum_q), .Add_Ovf(add_ovf_q),
    .Rsp_Valid(Rsp_Valid), .Rsp_Ready(Rsp_Ready), .Rsp_Id(Rsp_Id),
    .Rsp_Sum(Rsp_Sum), .Rsp_Ovf(Rsp_Ovf)
  );

  int vecs = 0;
  int errs = 0;
  int m_ptr = 0;
  int e_sum, e_ovf, e_id;
  logic [W-1:0] opa [NR];
  logic [W-1:0] opb [NR];

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, 32'(Gnt), 0);
    chk({tag, "_add_a"}, 32'(Add_A), 0);
    chk({tag, "_add_b"}, 32'(Add_B), 0);
    chk({tag, "_add_en"}, 32'(Add_En), 0);
    chk({tag, "_valid"}, 32'(Rsp_Valid), 0);
    chk({tag, "_id"}, 32'(Rsp_Id), 0);
    chk({tag, "_sum"}, 32'(Rsp_Sum), 0);
    chk({tag, "_ovf"}, 32'(Rsp_Ovf), 0);
  endtask

  // Reference arbitration: first requester at or after p, wrapping
  function automatic int model_winner(input logic [NR-1:0] m, input int p);
    for (int k = 0; k < NR; k++)
      if (m[(p + k) % NR]) return (p + k) % NR;
    return -1;
  endfunction

  function automatic int cur_ptr();
`ifdef ADDER_ARB_RR_EN
    return m_ptr;
`else
    return 0;
`endif
  endfunction

  // Present a request set, then check grant, issue and response timing
  task automatic start_op(input logic [NR-1:0] mask, input int fi,
                          input logic [W-1:0] fa, input logic [W-1:0] fb, output int w);
    int s;
    for (int i = 0; i < NR; i++) begin
      opa[i] = W'($urandom_range(0, 15));
      opb[i] = W'($urandom_range(0, 15));
    end
    if (fi >= 0) begin
      opa[fi] = fa;
      opb[fi] = fb;
    end
    for (int i = 0; i < NR; i++) begin
      Req_A[i*W +: W] = opa[i];
      Req_B[i*W +: W] = opb[i];
    end
    Req = mask;
    w = model_winner(mask, cur_ptr());
    s = int'(opa[w]) + int'(opb[w]);
    e_sum = s % 16;
    e_ovf = (s > 15) ? 1 : 0;
    e_id  = w;
    tick;
    chk("gnt", 32'(Gnt), 32'(1) << w);
    chk("add_en_hi", 32'(Add_En), 1);
    chk("add_a", 32'(Add_A), 32'(opa[w]));
    chk("add_b", 32'(Add_B), 32'(opb[w]));
    tick;
    chk("gnt_pulse", 32'(Gnt), 0);
    chk("add_en_lo", 32'(Add_En), 0);
    chk("valid_early", 32'(Rsp_Valid), 0);
    tick;
    chk("valid", 32'(Rsp_Valid), 1);
    chk("rsp_id", 32'(Rsp_Id), 32'(e_id));
    chk("rsp_sum", 32'(Rsp_Sum), 32'(e_sum));
    chk("rsp_ovf", 32'(Rsp_Ovf), 32'(e_ovf));
  endtask

  task automatic finish_op(input int w);
    tick;
    chk("valid_drop", 32'(Rsp_Valid), 0);
    m_ptr = (w + 1) % NR;
  endtask

  initial begin
    int w;
    logic [NR-1:0] pend;
    logic [NR-1:0] mask;

    Rst_n = 1'b0; Req = '0; Req_A = '0; Req_B = '0; Rsp_Ready = 1'b1;
    repeat (2) tick;
    chk_all_zero("rst");
    Rst_n = 1'b1;
    tick;

    // Reset while client 1's op is in WAIT
    Req_A[1*W +: W] = 4'd3; Req_B[1*W +: W] = 4'd5; Req = 4'b0010;
    tick;
    chk("rst_op_gnt", 32'(Gnt), 32'h2);
    Req = '0;
    tick;
    Rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    tick;
    Rst_n = 1'b1;
    m_ptr = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("no_rsp_after_rst", 32'(Rsp_Valid), 0);
    end

    // Single op with overflow
    start_op(4'b0100, 2, 4'd9, 4'd8, w);
    Req = '0;
    chk("sum_9p8", 32'(Rsp_Sum), 1);
    chk("ovf_9p8", 32'(Rsp_Ovf), 1);
    finish_op(w);

    // No overflow, Rsp_Valid exactly one cycle
    start_op(4'b0010, 1, 4'd7, 4'd8, w);
    Req = '0;
    chk("sum_7p8", 32'(Rsp_Sum), 15);
    chk("ovf_7p8", 32'(Rsp_Ovf), 0);
    finish_op(w);

    // Random request sets; losers stay pending until granted
    pend = '0;
    for (int n = 0; n < 12; n++) begin
      mask = pend | NR'($urandom_range(0, 15));
      if (mask == '0) mask = 4'b0001;
      start_op(mask, -1, '0, '0, w);
      pend = mask & ~(NR'(1) << w);
      Req = pend;
      finish_op(w);
    end

    // Contention from a fresh reset: all requests held
    Req = '0;
    Rst_n = 1'b0;
    tick;
    Rst_n = 1'b1;
    m_ptr = 0;
    tick;
    for (int n = 0; n < 5; n++) begin
      start_op(4'b1111, -1, '0, '0, w);
      finish_op(w);
    end

    // Backpressure: response held, no new grant
    Rsp_Ready = 1'b0;
    start_op(4'b1111, -1, '0, '0, w);
    for (int n = 0; n < 5; n++) begin
      tick;
      chk("bp_valid", 32'(Rsp_Valid), 1);
      chk("bp_id", 32'(Rsp_Id), 32'(e_id));
      chk("bp_sum", 32'(Rsp_Sum), 32'(e_sum));
      chk("bp_ovf", 32'(Rsp_Ovf), 32'(e_ovf));
      chk("bp_gnt", 32'(Gnt), 0);
      chk("bp_add_en", 32'(Add_En), 0);
    end
    Rsp_Ready = 1'b1;
    finish_op(w);
    tick;
    chk("bp_next_gnt", 32'(Gnt), 32'(1) << model_winner(4'b1111, cur_ptr()));
    Req = '0;
    repeat (4) tick;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
